// File: rtl/approx_sub_pipe.sv
// approx_sub_pipe: two-stage pipelined approximate subtractor D = A - B.
//
// The low WIDTH-APPROX_BITS bits are subtracted exactly and report their
// borrow on Bout. The top APPROX_BITS bits use the borrow-free rule
// D[i] = A[i] & ~B[i]. An exact difference is computed alongside, and
// err_flag marks results that differ from it. Two saturating counters
// track output transfers and erroneous transfers.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid / in_ready      upstream handshake for A, B
//   A, B                     minuend, subtrahend (WIDTH bits)
//   out_valid / out_ready    downstream handshake for D, Bout, err_flag
//   D                        approximate difference (WIDTH bits)
//   Bout                     borrow out of the exact low field
//   err_flag                 D differs from (A - B) mod 2^WIDTH
//   clr_stats                synchronous clear of both counters
//   err_count, sample_count  saturating statistics (CNT_W bits)
module approx_sub_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             err_flag,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    // Width of the exactly-subtracted low field.
    localparam int               L       = WIDTH - APPROX_BITS;
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> APPROX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reset is asserted asynchronously but released on a clock edge, so
    // every flop below leaves reset in the same cycle.
    logic rst_meta;
    logic rst_sync_n;

    // NOTE: sequential state always uses non-blocking (<=) assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Stage registers.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;

    logic s2_free;
    logic in_fire;
    logic out_fire;

    assign s2_free   = !s2_valid || out_ready;
    // Held low while reset is active or not yet released.
    assign in_ready  = rst_sync_n && (!s1_valid || s2_free);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    // Datapath from S1 into S2.
    logic [WIDTH-1:0] lo_a;
    logic [WIDTH-1:0] lo_b;
    logic [WIDTH-1:0] lo_diff;
    logic [WIDTH-1:0] exact;
    logic [WIDTH-1:0] approx;
    logic             lo_borrow;

    // NOTE: every signal assigned in always_comb receives a value on every
    // path (here via the unconditional loop) so no latch is inferred.
    always_comb begin
        lo_a      = s1_a & LO_MASK;
        lo_b      = s1_b & LO_MASK;
        // Only bits below L of this difference are used; the masked
        // operands make them the exact low-field difference mod 2^L.
        lo_diff   = lo_a - lo_b;
        lo_borrow = lo_a < lo_b;
        exact     = s1_a - s1_b;
        for (int i = 0; i < WIDTH; i++) begin
            approx[i] = (i < L) ? lo_diff[i] : (s1_a[i] & ~s1_b[i]);
        end
    end

    // NOTE: data registers are reset too, so outputs read 0 out of reset
    // rather than X; there is no memory array here that would forbid it.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            D        <= '0;
            Bout     <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            // S1 loads on an input handshake, empties when S2 takes it.
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end

            // S2 moves whenever its current result has gone or never was.
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    D        <= approx;
                    Bout     <= lo_borrow;
                    err_flag <= (approx != exact);
                end
            end
        end
    end

    // Statistics: clear has priority over a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            err_count    <= '0;
            sample_count <= '0;
        end else if (clr_stats) begin
            err_count    <= '0;
            sample_count <= '0;
        end else if (out_fire) begin
            if (sample_count != CNT_MAX) begin
                sample_count <= sample_count + 1'b1;
            end
            if (err_flag && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_approx_sub_pipe.sv
// Self-checking bench for approx_sub_pipe (WIDTH=8, APPROX_BITS=3, CNT_W=4).
// Results are compared through a scoreboard queue; counters against a model.
module tb_approx_sub_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             err_flag;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;

    approx_sub_pipe #(.WIDTH(WIDTH), .APPROX_BITS(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .Bout(Bout), .err_flag(err_flag),
        .clr_stats(clr_stats), .err_count(err_count), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bout;
        logic       err;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   out_count = 0;
    int   exp_samples = 0;
    int   exp_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: low 5 bits in integer arithmetic, top 3 bits
    // by the borrow-free rule, exact difference mod 256.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        int ai = int'(a);
        int bi = int'(b);
        int la = ai % 32;
        int lb = bi % 32;
        int lo = la - lb;
        int hi = (ai / 32) & ~(bi / 32) & 7;
        int ex = (ai - bi + 256) % 256;
        if (lo < 0) lo += 32;
        m.d    = 8'(hi * 32 + lo);
        m.bout = (la < lb);
        m.err  = (int'(m.d) != ex);
        return m;
    endfunction

    // Output monitor: scoreboard pops and counter model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("sample_count", 32'(sample_count), 32'(exp_samples));
            check("err_count", 32'(err_count), 32'(exp_errs));
            if (out_valid && out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("D", 32'(D), 32'(e.d));
                    check("Bout", 32'(Bout), 32'(e.bout));
                    check("err_flag", 32'(err_flag), 32'(e.err));
                end
            end
            if (clr_stats) begin
                exp_samples = 0;
                exp_errs = 0;
            end else if (out_valid && out_ready) begin
                if (exp_samples < 15) exp_samples++;
                if (err_flag && exp_errs < 15) exp_errs++;
            end
        end
    end

    // Hold A/B valid until accepted; push the expectation on acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        bit done = 0;
        A = a;
        B = b;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                accepts++;
                done = 1;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 60) begin
            @(posedge clk);
            c++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Result must be absent one cycle after capture and present the next.
    task automatic latency(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = model(a, b);
        send(a, b, e);
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_two_cycles", 32'(out_valid), 32'd1);
        check("lat_D", 32'(D), 32'(e.d));
    endtask

    initial begin
        vec_t tbl[8];
        exp_t e;
        logic [7:0] hold_d;
        bit held;
        int acc0, o0, c;

        tbl[0] = '{a: 8'hE5, b: 8'h21, d: 8'hC4, bout: 1'b0, err: 1'b0};
        tbl[1] = '{a: 8'hC8, b: 8'h32, d: 8'hD6, bout: 1'b1, err: 1'b1};
        tbl[2] = '{a: 8'h00, b: 8'h01, d: 8'h1F, bout: 1'b1, err: 1'b1};
        tbl[3] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bout: 1'b0, err: 1'b0};
        tbl[4] = '{a: 8'h80, b: 8'h7F, d: 8'h81, bout: 1'b1, err: 1'b1};
        tbl[5] = '{a: 8'h1F, b: 8'h20, d: 8'h1F, bout: 1'b0, err: 1'b1};
        tbl[6] = '{a: 8'h55, b: 8'h55, d: 8'h00, bout: 1'b0, err: 1'b0};
        tbl[7] = '{a: 8'hA0, b: 8'h40, d: 8'hA0, bout: 1'b0, err: 1'b1};

        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_samples", 32'(sample_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c = 0;
        while (!in_ready && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors, back to back, out_ready high.
        for (int i = 0; i < 8; i++) begin
            e = '{d: tbl[i].d, bout: tbl[i].bout, err: tbl[i].err};
            send(tbl[i].a, tbl[i].b, e);
        end
        drain();

        latency(8'h3C, 8'h5A);
        drain();

        // Back-pressure: out_ready low for the first cycles of a 4-vector burst.
        out_ready = 1'b0;
        acc0 = accepts;
        held = 0;
        hold_d = '0;
        fork
            begin
                send(8'hE5, 8'h21, model(8'hE5, 8'h21));
                send(8'hC8, 8'h32, model(8'hC8, 8'h32));
                send(8'h00, 8'h01, model(8'h00, 8'h01));
                send(8'hFF, 8'h00, model(8'hFF, 8'h00));
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!held) begin
                            held = 1;
                            hold_d = D;
                            check("bp_first_D", 32'(D), 32'h0000_00C4);
                        end else begin
                            check("bp_hold_D", 32'(D), 32'(hold_d));
                        end
                    end
                end
                check("bp_accepts", 32'(accepts - acc0), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                o0 = out_count;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_stream_valid", 32'(out_valid), 32'd1);
                end
                #1;
                check("bp_stream_count", 32'(out_count - o0), 32'd4);
            end
        join
        drain();

        // Saturation.
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        for (int i = 0; i < 20; i++) send(8'h00, 8'h01, model(8'h00, 8'h01));
        drain();
        check("sat_err", 32'(err_count), 32'd15);
        check("sat_samples", 32'(sample_count), 32'd15);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(8'hE5, 8'h21, model(8'hE5, 8'h21));
        send(8'hC8, 8'h32, model(8'hC8, 8'h32));
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        sb.delete();
        exp_samples = 0;
        exp_errs = 0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_err", 32'(err_count), 32'd0);
        check("arst_samples", 32'(sample_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        c = 0;
        while (!in_ready && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        latency(8'hC8, 8'h32);
        drain();

        // Clear in the same cycle as an output handshake.
        send(8'h80, 8'h7F, model(8'h80, 8'h7F));
        send(8'h55, 8'h55, model(8'h55, 8'h55));
        c = 0;
        while (!out_valid && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("clr_pre_valid", 32'(out_valid), 32'd1);
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        check("clr_err", 32'(err_count), 32'd0);
        check("clr_samples", 32'(sample_count), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
